// File: rtl/crc32_frame_engine.sv
// Frame-aware CRC-32 engine: one byte-masked beat per cycle, per-frame result,
// FCS residue check, and frame / bad-FCS counters.
module crc32_frame_engine #(
  parameter int          DATA_BYTES  = 8,
  parameter logic [31:0] POLY        = 32'hEDB88320,
  parameter logic [31:0] INITIAL_CRC = 32'hFFFFFFFF,
  parameter logic [31:0] FINAL_XOR   = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE     = 32'hDEBB20E3,
  parameter int          CNT_W       = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic                    i_start,
  input  logic                    i_last,
  input  logic [DATA_BYTES-1:0]   i_keep,
  input  logic [8*DATA_BYTES-1:0] i_data,
  output logic                    o_crc_valid,
  output logic [31:0]             o_crc,
  output logic                    o_fcs_ok,
  output logic                    o_proto_err,
  output logic [31:0]             o_frame_count,
  output logic [CNT_W-1:0]        o_bad_fcs_count
);

  typedef enum logic {IDLE, IN_FRAME} state_t;

  // Table entries are constant functions of the index, so they fold to constants.
  function automatic logic [31:0] table_entry(input logic [7:0] idx);
    logic [31:0] c;
    c = {24'd0, idx};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    end
    return c;
  endfunction

  logic [31:0] crc_table [256];

  for (genvar g = 0; g < 256; g++) begin : g_table
    assign crc_table[g] = table_entry(8'(g));
  end

  state_t           state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic             crc_valid_q, crc_valid_d;
  logic [31:0]      crc_out_q, crc_out_d;
  logic             fcs_ok_q, fcs_ok_d;
  logic             proto_err_q, proto_err_d;
  logic [31:0]      frame_count_q, frame_count_d;
  logic [CNT_W-1:0] bad_count_q, bad_count_d;
  logic [31:0]      stage_out;
  logic             accept;
  logic             emit;

  always_comb begin
    stage_out = i_start ? INITIAL_CRC : crc_q;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (i_keep[k]) begin
        stage_out = (stage_out >> 8) ^ crc_table[stage_out[7:0] ^ i_data[8*k +: 8]];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    crc_d         = crc_q;
    crc_valid_d   = 1'b0;
    crc_out_d     = crc_out_q;
    fcs_ok_d      = fcs_ok_q;
    proto_err_d   = 1'b0;
    frame_count_d = frame_count_q;
    bad_count_d   = bad_count_q;
    accept        = 1'b0;
    emit          = 1'b0;

    // A start inside an open frame abandons it and restarts with this beat.
    if (i_valid) begin
      if (i_start) begin
        accept      = 1'b1;
        proto_err_d = (state_q == IN_FRAME);
      end else if (state_q == IDLE) begin
        proto_err_d = 1'b1;
      end else begin
        accept = 1'b1;
      end
    end

    if (accept) begin
      crc_d   = stage_out;
      emit    = i_last;
      state_d = i_last ? IDLE : IN_FRAME;
    end

    if (emit) begin
      crc_valid_d   = 1'b1;
      crc_out_d     = stage_out ^ FINAL_XOR;
      fcs_ok_d      = (stage_out == RESIDUE);
      frame_count_d = frame_count_q + 32'd1;
      if ((stage_out != RESIDUE) && (bad_count_q != {CNT_W{1'b1}})) begin
        bad_count_d = bad_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= IDLE;
      crc_q         <= INITIAL_CRC;
      crc_valid_q   <= 1'b0;
      crc_out_q     <= 32'd0;
      fcs_ok_q      <= 1'b0;
      proto_err_q   <= 1'b0;
      frame_count_q <= 32'd0;
      bad_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      crc_q         <= crc_d;
      crc_valid_q   <= crc_valid_d;
      crc_out_q     <= crc_out_d;
      fcs_ok_q      <= fcs_ok_d;
      proto_err_q   <= proto_err_d;
      frame_count_q <= frame_count_d;
      bad_count_q   <= bad_count_d;
    end
  end

  assign o_crc_valid     = crc_valid_q;
  assign o_crc           = crc_out_q;
  assign o_fcs_ok        = fcs_ok_q;
  assign o_proto_err     = proto_err_q;
  assign o_frame_count   = frame_count_q;
  assign o_bad_fcs_count = bad_count_q;

endmodule
